// File: rtl/omsp_hmac_arbiter_if.sv
// Bundle of the two requester ports and the shared HMAC port.
// The slave modport is the arbiter's view; the master modport is the environment around it.
interface omsp_hmac_arbiter_if #(
   parameter int KEY_SIZE = 128
);
   logic                req0, req1;
   logic                start_continue0, start_continue1;
   logic                data_available0, data_available1;
   logic                data_is_long0, data_is_long1;
   logic [KEY_SIZE-1:0] key0, key1;
   logic [15:0]         data_in0, data_in1;
   logic                gnt0, gnt1;
   logic                busy0, busy1;
   logic [15:0]         data_out0, data_out1;
   logic                hm_reset;
   logic                hm_start_continue, hm_data_available, hm_data_is_long;
   logic [KEY_SIZE-1:0] hm_key;
   logic [15:0]         hm_data_in;
   logic [15:0]         hm_data_out;
   logic                hm_busy;

   modport slave (
      input  req0, req1, start_continue0, start_continue1,
      input  data_available0, data_available1, data_is_long0, data_is_long1,
      input  key0, key1, data_in0, data_in1, hm_data_out, hm_busy,
      output gnt0, gnt1, busy0, busy1, data_out0, data_out1,
      output hm_reset, hm_start_continue, hm_data_available, hm_data_is_long,
      output hm_key, hm_data_in
   );

   modport master (
      output req0, req1, start_continue0, start_continue1,
      output data_available0, data_available1, data_is_long0, data_is_long1,
      output key0, key1, data_in0, data_in1, hm_data_out, hm_busy,
      input  gnt0, gnt1, busy0, busy1, data_out0, data_out1,
      input  hm_reset, hm_start_continue, hm_data_available, hm_data_is_long,
      input  hm_key, hm_data_in
   );
endinterface

// File: rtl/omsp_hmac_arbiter.sv
// Session arbiter sharing one omsp_hmac_16bit between two requesters.
// Round-robin whole-session grants, key latched at grant, HMAC scrubbed on every handover.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_SCRUB | hm_reset held high for SCRUB_CYCLES cycles, key register zeroed
// ST_IDLE  | HMAC clean, arbitrating between pending requests
// ST_OWNED | owner's handshake forwarded to the HMAC
// ST_DRAIN | owner released while HMAC busy; controls forced low until idle
module omsp_hmac_arbiter #(
   parameter int KEY_SIZE     = 128,
   parameter int SCRUB_CYCLES = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   omsp_hmac_arbiter_if.slave       bus
);

   typedef enum logic [1:0] {ST_SCRUB, ST_IDLE, ST_OWNED, ST_DRAIN} state_t;

   localparam logic [3:0] SCRUB_INIT = 4'(SCRUB_CYCLES - 1);

   state_t              state_q, state_d;
   logic                owner_q, owner_d;
   logic                last_q, last_d;
   logic [KEY_SIZE-1:0] key_q, key_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                gnt0_q, gnt1_q;
   logic                own_req, win;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_SCRUB;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         key_q   <= '0;
         cnt_q   <= SCRUB_INIT;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         key_q   <= key_d;
         cnt_q   <= cnt_d;
         gnt0_q  <= (state_d == ST_OWNED) && !owner_d;
         gnt1_q  <= (state_d == ST_OWNED) &&  owner_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      key_d   = key_q;
      cnt_d   = cnt_q;
      win     = 1'b0;
      own_req = owner_q ? bus.req1 : bus.req0;
      case (state_q)
         ST_SCRUB: begin
            key_d = '0;
            if (cnt_q == 4'd0) state_d = ST_IDLE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ST_IDLE: begin
            if (bus.req0 || bus.req1) begin
               // on a tie the port that did not own last time wins
               win     = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
               owner_d = win;
               last_d  = win;
               key_d   = win ? bus.key1 : bus.key0;
               state_d = ST_OWNED;
            end
         end
         ST_OWNED: begin
            if (!own_req) begin
               if (bus.hm_busy) begin
                  state_d = ST_DRAIN;
               end else begin
                  state_d = ST_SCRUB;
                  cnt_d   = SCRUB_INIT;
                  key_d   = '0;
               end
            end
         end
         ST_DRAIN: begin
            if (!bus.hm_busy) begin
               state_d = ST_SCRUB;
               cnt_d   = SCRUB_INIT;
               key_d   = '0;
            end
         end
         default: state_d = ST_SCRUB;
      endcase
   end

   wire owned = (state_q == ST_OWNED);

   assign bus.hm_reset          = (state_q == ST_SCRUB);
   assign bus.hm_key            = key_q;
   assign bus.hm_start_continue = owned && (owner_q ? bus.start_continue1 : bus.start_continue0);
   assign bus.hm_data_available = owned && (owner_q ? bus.data_available1 : bus.data_available0);
   assign bus.hm_data_is_long   = owned && (owner_q ? bus.data_is_long1 : bus.data_is_long0);
   assign bus.hm_data_in        = !owned ? 16'h0000 : (owner_q ? bus.data_in1 : bus.data_in0);

   // gnt registers track (state == OWNED && owner == N) exactly, so they gate the returns
   assign bus.gnt0      = gnt0_q;
   assign bus.gnt1      = gnt1_q;
   assign bus.busy0     = gnt0_q ? bus.hm_busy : 1'b1;
   assign bus.busy1     = gnt1_q ? bus.hm_busy : 1'b1;
   assign bus.data_out0 = gnt0_q ? bus.hm_data_out : 16'h0000;
   assign bus.data_out1 = gnt1_q ? bus.hm_data_out : 16'h0000;

endmodule
